// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller beside ID: tracks in-flight load destinations, the MDU busy window
// and multi-cycle front-end flushes, and drives the pause/wash controls of the pipeline registers.
module pipe_hazard_ctrl #(
   parameter int unsigned SB_DEPTH  = 4,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned MUL_LAT   = 4,
   parameter int unsigned DIV_LAT   = 32,
   parameter int unsigned FLUSH_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_rs_en_i,
   input  logic       id_rt_en_i,
   input  logic       id_load_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_hilo_rd_i,
   input  logic       id_mdu_i,
   input  logic       id_mdu_div_i,
   input  logic       id_trap_i,
   input  logic       id_redirect_i,
   input  logic       cp0_interrupt_i,
   input  logic       cp0_exc_i,
   input  logic       cp0_exc_byinstr_i,
   output logic       pa_pc_ifid_o,
   output logic       pa_idexmemwr_o,
   output logic       wash_ifid_o,
   output logic       wash_idex_o,
   output logic       wash_exmem_o,
   output logic       wash_memwr_o,
   output logic       mdu_busy_o
);

   localparam int unsigned LdW    = $clog2(LOAD_LAT + 1);
   localparam int unsigned MduMax = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int unsigned MdW    = $clog2(MduMax + 1);
   localparam int unsigned FlW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   localparam logic StRun   = 1'b0;
   localparam logic StFlush = 1'b1;

   logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
   logic [4:0]          sb_reg_q [SB_DEPTH];
   logic [4:0]          sb_reg_d [SB_DEPTH];
   logic [LdW-1:0]      sb_cnt_q [SB_DEPTH];
   logic [LdW-1:0]      sb_cnt_d [SB_DEPTH];
   logic [MdW-1:0]      mdu_cnt_q, mdu_cnt_d;
   logic                state_q, state_d;
   logic [FlW-1:0]      flush_rem_q, flush_rem_d;

   logic [SB_DEPTH-1:0] sb_freeing;
   logic                sb_hit, sb_full, mdu_haz, dexc, stall, issue, flush_trig;

   assign dexc = cp0_exc_i & ~cp0_exc_byinstr_i;

   always_comb begin
      sb_hit     = 1'b0;
      sb_freeing = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         sb_freeing[i] = sb_vld_q[i] & (sb_cnt_q[i] == LdW'(1));
         if (sb_vld_q[i] && (sb_cnt_q[i] != '0) && (sb_reg_q[i] != 5'd0) &&
             ((id_rs_en_i && (sb_reg_q[i] == id_rs_i)) ||
              (id_rt_en_i && (sb_reg_q[i] == id_rt_i)))) begin
            sb_hit = 1'b1;
         end
      end
   end

   assign sb_full    = id_load_i & (&sb_vld_q) & ~(|sb_freeing);
   assign mdu_busy_o = (mdu_cnt_q != '0);
   assign mdu_haz    = mdu_busy_o & (id_hilo_rd_i | id_mdu_i);
   assign stall      = id_valid_i & (sb_hit | sb_full | mdu_haz) & ~dexc;
   assign issue      = id_valid_i & ~pause_i & ~stall & ~dexc;
   // A data exception also raises cp0_exc_i, so it restarts the flush window too.
   assign flush_trig = ~stall & (id_trap_i | cp0_exc_i | cp0_interrupt_i);

   always_comb begin
      pa_pc_ifid_o   = 1'b1;
      pa_idexmemwr_o = 1'b1;
      wash_ifid_o    = 1'b0;
      wash_idex_o    = 1'b0;
      wash_exmem_o   = 1'b0;
      wash_memwr_o   = 1'b0;
      if (!pause_i) begin
         pa_pc_ifid_o   = stall;
         pa_idexmemwr_o = 1'b0;
         wash_ifid_o    = flush_trig | (~stall & (id_redirect_i | (state_q == StFlush)));
         wash_idex_o    = dexc | stall;
         wash_exmem_o   = dexc;
         wash_memwr_o   = dexc;
      end
   end

   always_comb begin
      logic alloc_done;
      alloc_done = 1'b0;
      sb_vld_d   = sb_vld_q;
      sb_reg_d   = sb_reg_q;
      sb_cnt_d   = sb_cnt_q;
      if (!pause_i) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld_q[i]) begin
               sb_cnt_d[i] = sb_cnt_q[i] - LdW'(1);
               if (sb_cnt_q[i] <= LdW'(1)) sb_vld_d[i] = 1'b0;
            end
         end
         if (dexc) begin
            sb_vld_d = '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_cnt_d[i] = '0;
         end else if (issue && id_load_i && (id_rd_i != 5'd0)) begin
            // An entry retiring this cycle is free for reuse.
            for (int i = 0; i < SB_DEPTH; i++) begin
               if (!alloc_done && (!sb_vld_q[i] || sb_freeing[i])) begin
                  alloc_done  = 1'b1;
                  sb_vld_d[i] = 1'b1;
                  sb_reg_d[i] = id_rd_i;
                  sb_cnt_d[i] = LdW'(LOAD_LAT);
               end
            end
         end
      end
   end

   always_comb begin
      mdu_cnt_d   = mdu_cnt_q;
      state_d     = state_q;
      flush_rem_d = flush_rem_q;
      if (!pause_i) begin
         if (dexc) begin
            mdu_cnt_d = '0;
         end else if (issue && id_mdu_i) begin
            mdu_cnt_d = id_mdu_div_i ? MdW'(DIV_LAT) : MdW'(MUL_LAT);
         end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MdW'(1);
         end

         if (flush_trig) begin
            if (FLUSH_CYC > 1) begin
               state_d     = StFlush;
               flush_rem_d = FlW'(FLUSH_CYC - 1);
            end else begin
               state_d     = StRun;
               flush_rem_d = '0;
            end
         end else if (state_q == StFlush) begin
            if (flush_rem_q <= FlW'(1)) begin
               state_d     = StRun;
               flush_rem_d = '0;
            end else begin
               flush_rem_d = flush_rem_q - FlW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_vld_q    <= '0;
         mdu_cnt_q   <= '0;
         state_q     <= StRun;
         flush_rem_q <= '0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_reg_q[i] <= '0;
            sb_cnt_q[i] <= '0;
         end
      end else begin
         sb_vld_q    <= sb_vld_d;
         mdu_cnt_q   <= mdu_cnt_d;
         state_q     <= state_d;
         flush_rem_q <= flush_rem_d;
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_reg_q[i] <= sb_reg_d[i];
            sb_cnt_q[i] <= sb_cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: each stimulus cycle queues its hand-computed expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic pause_i, id_valid_i, id_rs_en_i, id_rt_en_i, id_load_i;
   logic [4:0] id_rs_i, id_rt_i, id_rd_i;
   logic id_hilo_rd_i, id_mdu_i, id_mdu_div_i, id_trap_i, id_redirect_i;
   logic cp0_interrupt_i, cp0_exc_i, cp0_exc_byinstr_i;
   logic pa_pc_ifid_o, pa_idexmemwr_o, wash_ifid_o, wash_idex_o, wash_exmem_o, wash_memwr_o;
   logic mdu_busy_o;

   // {pa_pc_ifid, pa_idexmemwr, wash_ifid, wash_idex, wash_exmem, wash_memwr, mdu_busy}
   localparam logic [6:0] E0 = 7'b0000000;
   localparam logic [6:0] ES = 7'b1001000;
   localparam logic [6:0] EP = 7'b1100000;
   localparam logic [6:0] EW = 7'b0010000;
   localparam logic [6:0] EB = 7'b0000001;

   typedef struct {
      string      name;
      logic [6:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   pipe_hazard_ctrl #(
      .SB_DEPTH (2),
      .LOAD_LAT (3),
      .MUL_LAT  (4),
      .DIV_LAT  (32),
      .FLUSH_CYC(3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .pause_i          (pause_i),
      .id_valid_i       (id_valid_i),
      .id_rs_i          (id_rs_i),
      .id_rt_i          (id_rt_i),
      .id_rs_en_i       (id_rs_en_i),
      .id_rt_en_i       (id_rt_en_i),
      .id_load_i        (id_load_i),
      .id_rd_i          (id_rd_i),
      .id_hilo_rd_i     (id_hilo_rd_i),
      .id_mdu_i         (id_mdu_i),
      .id_mdu_div_i     (id_mdu_div_i),
      .id_trap_i        (id_trap_i),
      .id_redirect_i    (id_redirect_i),
      .cp0_interrupt_i  (cp0_interrupt_i),
      .cp0_exc_i        (cp0_exc_i),
      .cp0_exc_byinstr_i(cp0_exc_byinstr_i),
      .pa_pc_ifid_o     (pa_pc_ifid_o),
      .pa_idexmemwr_o   (pa_idexmemwr_o),
      .wash_ifid_o      (wash_ifid_o),
      .wash_idex_o      (wash_idex_o),
      .wash_exmem_o     (wash_exmem_o),
      .wash_memwr_o     (wash_memwr_o),
      .mdu_busy_o       (mdu_busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t       e;
         logic [6:0] act;
         e   = exp_q.pop_front();
         act = {pa_pc_ifid_o, pa_idexmemwr_o, wash_ifid_o, wash_idex_o, wash_exmem_o,
                wash_memwr_o, mdu_busy_o};
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", e.name, act, e.exp);
         end
      end
   end

   task automatic clr_in();
      pause_i = 0; id_valid_i = 0; id_rs_en_i = 0; id_rt_en_i = 0; id_load_i = 0;
      id_rs_i = 0; id_rt_i = 0; id_rd_i = 0; id_hilo_rd_i = 0; id_mdu_i = 0;
      id_mdu_div_i = 0; id_trap_i = 0; id_redirect_i = 0; cp0_interrupt_i = 0;
      cp0_exc_i = 0; cp0_exc_byinstr_i = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   task automatic chk(input string n, input logic [6:0] e);
      exp_t t;
      t.name = n;
      t.exp  = e;
      exp_q.push_back(t);
   endtask

   task automatic ld(input logic [4:0] rd, input string n, input logic [6:0] e);
      cyc(); id_valid_i = 1; id_load_i = 1; id_rd_i = rd; chk(n, e);
   endtask

   task automatic use_rs(input logic [4:0] rs, input string n, input logic [6:0] e);
      cyc(); id_valid_i = 1; id_rs_en_i = 1; id_rs_i = rs; chk(n, e);
   endtask

   task automatic idle(input string n, input logic [6:0] e);
      cyc(); chk(n, e);
   endtask

   task automatic mflo(input string n, input logic [6:0] e);
      cyc(); id_valid_i = 1; id_hilo_rd_i = 1; chk(n, e);
   endtask

   initial begin
      clr_in();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      idle("reset", E0);

      // Load-use with LOAD_LAT=3: three stall cycles, release on the fourth.
      ld(5'd5, "ld_r5", E0);
      for (int i = 0; i < 3; i++) use_rs(5'd5, $sformatf("use_r5_stall%0d", i), ES);
      use_rs(5'd5, "use_r5_release", E0);

      // r0 destination is never tracked.
      ld(5'd0, "ld_r0", E0);
      use_rs(5'd0, "use_r0", E0);

      // rt path, and a disabled rs port must not match.
      ld(5'd7, "ld_r7", E0);
      cyc(); id_valid_i = 1; id_rs_i = 7; id_rt_i = 7; id_rt_en_i = 1; chk("use_rt7", ES);
      cyc(); id_valid_i = 1; id_rs_i = 7; id_rt_i = 3; id_rt_en_i = 1; chk("rs_dis", E0);
      idle("drain_r7", E0);

      // No stall when ID holds a bubble.
      ld(5'd9, "ld_r9", E0);
      cyc(); id_rs_i = 9; id_rs_en_i = 1; chk("bubble_r9", E0);
      idle("drain_r9a", E0);
      idle("drain_r9b", E0);

      // Scoreboard full with SB_DEPTH=2: third load waits for the first entry to free.
      ld(5'd1, "ld_r1", E0);
      ld(5'd2, "ld_r2", E0);
      ld(5'd3, "ld_r3_full", ES);
      ld(5'd3, "ld_r3_issue", E0);
      cyc(); id_valid_i = 1; id_rt_i = 2; id_rt_en_i = 1; chk("use_r2_stall", ES);
      cyc(); id_valid_i = 1; id_rt_i = 2; id_rt_en_i = 1; chk("use_r2_go", E0);
      idle("drain_r3", E0);

      // pause_i freezes the scoreboard and forces the pause pattern.
      ld(5'd4, "ld_r4", E0);
      use_rs(5'd4, "use_r4_s0", ES);
      cyc(); pause_i = 1; id_valid_i = 1; id_rs_en_i = 1; id_rs_i = 4; chk("paused", EP);
      use_rs(5'd4, "use_r4_s1", ES);
      use_rs(5'd4, "use_r4_s2", ES);
      use_rs(5'd4, "use_r4_go", E0);

      // MULT: busy 4 cycles, unrelated instr does not stall.
      cyc(); id_valid_i = 1; id_mdu_i = 1; chk("mult", E0);
      use_rs(5'd10, "mult_indep", EB);
      for (int i = 0; i < 3; i++) mflo($sformatf("mult_mflo%0d", i), ES | EB);
      mflo("mult_mflo_go", E0);

      // DIV: MFLO stalls 32 cycles; a second MDU op also stalls.
      cyc(); id_valid_i = 1; id_mdu_i = 1; id_mdu_div_i = 1; chk("div", E0);
      for (int i = 0; i < 32; i++) begin
         if (i == 5) begin
            cyc(); id_valid_i = 1; id_mdu_i = 1; chk("div_mthi", ES | EB);
         end else begin
            mflo($sformatf("div_mflo%0d", i), ES | EB);
         end
      end
      mflo("div_mflo_go", E0);

      // SYSCALL with FLUSH_CYC=3, pause mid-flush extends the window.
      cyc(); id_valid_i = 1; id_trap_i = 1; chk("trap", EW);
      idle("flush1", EW);
      cyc(); pause_i = 1; chk("flush_paused", EP);
      idle("flush2", EW);
      idle("flush_done", E0);

      // Redirect alone washes one slot only.
      cyc(); id_redirect_i = 1; chk("redirect", EW);
      idle("redirect_done", E0);

      // Interrupt, then trap inside FLUSH reloads the window.
      cyc(); cp0_interrupt_i = 1; chk("irq", EW);
      idle("irq_f1", EW);
      cyc(); id_valid_i = 1; id_trap_i = 1; chk("retrap", EW);
      idle("retrap_f1", EW);
      idle("retrap_f2", EW);
      idle("retrap_done", E0);

      // Instruction-fetch TLB exception: front-end flush only.
      cyc(); cp0_exc_i = 1; cp0_exc_byinstr_i = 1; chk("itlb", EW);
      idle("itlb_f1", EW);
      idle("itlb_f2", EW);
      idle("itlb_done", E0);

      // Data TLB exception coincident with load-use and MDU busy.
      cyc(); id_valid_i = 1; id_mdu_i = 1; chk("dexc_mult", E0);
      ld(5'd6, "dexc_ld_r6", EB);
      cyc(); id_valid_i = 1; id_rs_en_i = 1; id_rs_i = 6; cp0_exc_i = 1;
      chk("dexc", 7'b0011111);
      cyc(); id_valid_i = 1; id_rs_en_i = 1; id_rs_i = 6; id_hilo_rd_i = 1;
      chk("dexc_cleared", EW);
      idle("dexc_f2", EW);
      idle("dexc_done", E0);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
